level_pattern_gen: RTL and testbench

//  Transmit-side counterpart of the level-pattern detector: on request, drives a

---
 rtl/level_pattern_gen.sv | 175 +++++++++++++++++
 tb/tb_level_pattern_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/level_pattern_gen.sv
// -----------------------------------------------------------------------------
// level_pattern_gen
//  Transmit-side pattern source for the level-pattern detector. When a start
//  request is accepted in IDLE, it drives 'level' with n_pulses high phases of
//  high_len cycles. Each high phase is followed by a low gap of low_len cycles,
//  and this includes a trailing gap after the last pulse. It then pulses 'done'
//  for one cycle.
//
// Ports
//  clk       in   1      system clock, rising edge
//  reset_n   in   1      asynchronous, active-low reset
//  start     in   1      request; accepted only in IDLE
//  abort     in   1      synchronous cancel of a running pattern
//  n_pulses  in   CNT_W  number of high pulses, sampled on accept
//  high_len  in   LEN_W  cycles per high phase, sampled on accept (0 -> 1)
//  low_len   in   LEN_W  cycles per low phase, sampled on accept (0 -> 1)
//  level     out  1      generated line, registered
//  busy      out  1      high from the cycle after accept until done
//  done      out  1      one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module level_pattern_gen #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] n_pulses,
    input  logic [LEN_W-1:0] high_len,
    input  logic [LEN_W-1:0] low_len,
    output logic             level,
    output logic             busy,
    output logic             done
);

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIGH = 2'b01,
        ST_LOW  = 2'b10
    } state_t;

    state_t           state_r,     state_s;
    logic [LEN_W-1:0] phase_cnt_r, phase_cnt_s;
    logic [CNT_W-1:0] pulse_cnt_r, pulse_cnt_s;
    logic [LEN_W-1:0] high_len_r,  high_len_s;
    logic [LEN_W-1:0] low_len_r,   low_len_s;
    logic             level_r,     level_s;
    logic             busy_r,      busy_s;
    logic             done_r,      done_s;

    // A zero-length phase would otherwise never terminate; run it as one cycle.
    function automatic logic [LEN_W-1:0] len_fix(input logic [LEN_W-1:0] len);
        if (len == LEN_ZERO) begin
            return LEN_ONE;
        end else begin
            return len;
        end
    endfunction

    // Next-state and next-output logic; outputs are computed here and registered below.
    always_comb begin
        state_s     = state_r;
        phase_cnt_s = phase_cnt_r;
        pulse_cnt_s = pulse_cnt_r;
        high_len_s  = high_len_r;
        low_len_s   = low_len_r;
        level_s     = level_r;
        busy_s      = busy_r;
        done_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                level_s = 1'b0;
                busy_s  = 1'b0;
                // abort in IDLE suppresses a simultaneous start
                if (start && !abort) begin
                    high_len_s = len_fix(high_len);
                    low_len_s  = len_fix(low_len);
                    if (n_pulses == CNT_ZERO) begin
                        done_s = 1'b1;
                    end else begin
                        state_s     = ST_HIGH;
                        level_s     = 1'b1;
                        busy_s      = 1'b1;
                        pulse_cnt_s = n_pulses;
                        phase_cnt_s = len_fix(high_len);
                    end
                end else begin
                    phase_cnt_s = LEN_ZERO;
                end
            end

            ST_HIGH: begin
                if (abort) begin
                    state_s     = ST_IDLE;
                    level_s     = 1'b0;
                    busy_s      = 1'b0;
                    phase_cnt_s = LEN_ZERO;
                    pulse_cnt_s = CNT_ZERO;
                end else if (phase_cnt_r > LEN_ONE) begin
                    phase_cnt_s = phase_cnt_r - LEN_ONE;
                end else begin
                    // a pulse counts as sent once its high phase ends
                    state_s     = ST_LOW;
                    level_s     = 1'b0;
                    phase_cnt_s = low_len_r;
                    pulse_cnt_s = pulse_cnt_r - CNT_ONE;
                end
            end

            ST_LOW: begin
                if (abort) begin
                    state_s     = ST_IDLE;
                    level_s     = 1'b0;
                    busy_s      = 1'b0;
                    phase_cnt_s = LEN_ZERO;
                    pulse_cnt_s = CNT_ZERO;
                end else if (phase_cnt_r > LEN_ONE) begin
                    phase_cnt_s = phase_cnt_r - LEN_ONE;
                end else if (pulse_cnt_r != CNT_ZERO) begin
                    state_s     = ST_HIGH;
                    level_s     = 1'b1;
                    phase_cnt_s = high_len_r;
                end else begin
                    state_s     = ST_IDLE;
                    busy_s      = 1'b0;
                    done_s      = 1'b1;
                    phase_cnt_s = LEN_ZERO;
                end
            end

            default: begin
                state_s     = ST_IDLE;
                level_s     = 1'b0;
                busy_s      = 1'b0;
                phase_cnt_s = LEN_ZERO;
                pulse_cnt_s = CNT_ZERO;
            end
        endcase
    end

    // State, counter, latched-length and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            phase_cnt_r <= LEN_ZERO;
            pulse_cnt_r <= CNT_ZERO;
            high_len_r  <= LEN_ZERO;
            low_len_r   <= LEN_ZERO;
            level_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            phase_cnt_r <= phase_cnt_s;
            pulse_cnt_r <= pulse_cnt_s;
            high_len_r  <= high_len_s;
            low_len_r   <= low_len_s;
            level_r     <= level_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign level = level_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_level_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_level_pattern_gen
//  Directed bench for level_pattern_gen. A behavioural model expands each
//  accepted request into the full list of per-cycle (level, busy, done)
//  values. The outputs are checked against this list on every cycle. Some
//  hand-computed literals pin the model.
// -----------------------------------------------------------------------------
module tb_level_pattern_gen;

    localparam int LEN_W = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] n_pulses;
    logic [LEN_W-1:0] high_len;
    logic [LEN_W-1:0] low_len;
    logic             level;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    level_pattern_gen #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .abort    (abort),
        .n_pulses (n_pulses),
        .high_len (high_len),
        .low_len  (low_len),
        .level    (level),
        .busy     (busy),
        .done     (done)
    );

    typedef struct packed {
        logic lv;
        logic bz;
        logic dn;
    } obs_t;

    obs_t        exp_q[$];
    obs_t        cur;
    int          checks   = 0;
    int          failures = 0;
    int          rises;
    int          cyc;
    logic        prev_lv;
    logic [15:0] cap_lv;
    logic [15:0] cap_dn;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Expand one accepted request into its complete per-cycle output sequence.
    task automatic load(input int n, input int h, input int l);
        obs_t e;
        int he;
        int le;
        he = (h == 0) ? 1 : h;
        le = (l == 0) ? 1 : l;
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < he; i++) begin
                e = '{lv: 1'b1, bz: 1'b1, dn: 1'b0};
                exp_q.push_back(e);
            end
            for (int i = 0; i < le; i++) begin
                e = '{lv: 1'b0, bz: 1'b1, dn: 1'b0};
                exp_q.push_back(e);
            end
        end
        e = '{lv: 1'b0, bz: 1'b0, dn: 1'b1};
        exp_q.push_back(e);
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        if (!reset_n) begin
            exp_q.delete();
            cur = '0;
        end else begin
            if (abort && cur.bz) begin
                exp_q.delete();
            end else if (!cur.bz && start && !abort) begin
                load(int'(n_pulses), int'(high_len), int'(low_len));
            end
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
            end else begin
                cur = '0;
            end
        end
        @(negedge clk);
        check_val("cyc_level", {31'd0, level}, {31'd0, cur.lv});
        check_val("cyc_busy",  {31'd0, busy},  {31'd0, cur.bz});
        check_val("cyc_done",  {31'd0, done},  {31'd0, cur.dn});
        if (level && !prev_lv) begin
            rises++;
        end
        prev_lv = level;
        cap_lv  = {cap_lv[14:0], level};
        cap_dn  = {cap_dn[14:0], done};
    endtask

    task automatic request(input int n, input int h, input int l);
        n_pulses = CNT_W'(n);
        high_len = LEN_W'(h);
        low_len  = LEN_W'(l);
        start    = 1'b1;
    endtask

    initial begin
        cur      = '0;
        rises    = 0;
        prev_lv  = 1'b0;
        cap_lv   = 16'd0;
        cap_dn   = 16'd0;
        reset_n  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        n_pulses = 8'd0;
        high_len = 8'd0;
        low_len  = 8'd0;
        step();
        step();
        reset_n = 1'b1;
        step();

        // Reset asserted in the middle of a high phase
        request(1, 10, 2);
        step();
        start = 1'b0;
        step();
        step();
        check_val("pre_reset_level", {31'd0, level}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_val("async_reset_level", {31'd0, level}, 32'd0);
        check_val("async_reset_busy",  {31'd0, busy},  32'd0);
        step();
        step();
        reset_n = 1'b1;
        step();
        step();

        // n=1, high=3, low=2: level 1,1,1,0,0 then done on cycle 6
        cap_lv = 16'd0;
        cap_dn = 16'd0;
        request(1, 3, 2);
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_val("t2_level_trace", {26'd0, cap_lv[5:0]}, 32'b111000);
        check_val("t2_done_trace",  {26'd0, cap_dn[5:0]}, 32'b000001);

        // n=3, high=2, low=4: 18 cycles from first high to done, detector sees 2 ticks
        rises   = 0;
        prev_lv = 1'b0;
        request(3, 2, 4);
        step();
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        check_val("t3_pattern_len", cyc - 1, 32'd18);
        check_val("t3_ticks", rises - 1, 32'd2);

        // start in the done cycle is accepted; level rises the next cycle
        request(1, 1, 1);
        step();
        start = 1'b0;
        check_val("start_on_done_level", {31'd0, level}, 32'd1);
        check_val("start_on_done_busy",  {31'd0, busy},  32'd1);
        step();
        step();
        check_val("start_on_done_finish", {31'd0, done}, 32'd1);
        step();

        // n=0: done next cycle, never busy, never high
        request(0, 5, 5);
        step();
        start = 1'b0;
        check_val("t4_done",  {31'd0, done},  32'd1);
        check_val("t4_busy",  {31'd0, busy},  32'd0);
        check_val("t4_level", {31'd0, level}, 32'd0);
        step();
        step();

        // zero lengths treated as 1; start while busy ignored
        cap_lv = 16'd0;
        cap_dn = 16'd0;
        request(2, 0, 0);
        step();
        request(5, 7, 7);
        step();
        step();
        start = 1'b0;
        step();
        step();
        check_val("t5_level_trace", {27'd0, cap_lv[4:0]}, 32'b10100);
        check_val("t5_done_trace",  {27'd0, cap_dn[4:0]}, 32'b00001);
        step();
        step();

        // abort on the second low cycle of a two-pulse pattern
        request(2, 2, 3);
        step();
        start = 1'b0;
        step();
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_val("t6_abort_level", {31'd0, level}, 32'd0);
        check_val("t6_abort_busy",  {31'd0, busy},  32'd0);
        check_val("t6_abort_done",  {31'd0, done},  32'd0);
        cap_dn = 16'd0;
        for (int i = 0; i < 6; i++) step();
        check_val("t6_no_done", {16'd0, cap_dn}, 32'd0);
        request(1, 2, 1);
        step();
        start = 1'b0;
        check_val("t6_restart_level", {31'd0, level}, 32'd1);
        for (int i = 0; i < 4; i++) step();

        // abort and start together in IDLE: start ignored
        request(1, 2, 2);
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check_val("idle_abort_start_busy", {31'd0, busy}, 32'd0);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
